// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// datapath mux selects and the bundled control-word type.
package mips_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9,
      ST_ADDIEX = 4'd10,
      ST_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALUB_REG     = 2'b00;
   localparam logic [1:0] ALUB_FOUR    = 2'b01;
   localparam logic [1:0] ALUB_IMM     = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       instr_done;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_J, OP_BEQ, OP_LW, OP_SW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: maps the current state (plus mem_ready for the
// memory-handshake states) to the datapath control word; all zero in reset.
module mc_outdec
   import mips_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   rst,
   output ctrl_t  ctrl
);

   always_comb begin
      // NOTE: every field gets a default before the case so no path can
      // leave a control bit unassigned and infer a latch.
      ctrl = '0;
      if (!rst) begin
         case (state)
            ST_FETCH: begin
               ctrl.memread = 1'b1;
               ctrl.alusrcb = ALUB_FOUR;
               ctrl.irwrite = mem_ready;
               ctrl.pcwrite = mem_ready;
            end
            ST_DECODE: ctrl.alusrcb = ALUB_IMM_SH2;
            ST_MEMADR, ST_ADDIEX: begin
               ctrl.alusrca = 1'b1;
               ctrl.alusrcb = ALUB_IMM;
            end
            ST_MEMRD: begin
               ctrl.memread = 1'b1;
               ctrl.iord    = 1'b1;
            end
            ST_MEMWR: begin
               ctrl.memwrite   = 1'b1;
               ctrl.iord       = 1'b1;
               ctrl.instr_done = mem_ready;
            end
            ST_MEMWB: begin
               ctrl.regwrite   = 1'b1;
               ctrl.memtoreg   = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            ST_EXEC: begin
               ctrl.alusrca = 1'b1;
               ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
               ctrl.regwrite   = 1'b1;
               ctrl.regdst     = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            ST_ADDIWB: begin
               ctrl.regwrite   = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
               ctrl.alusrca     = 1'b1;
               ctrl.aluop       = ALUOP_SUB;
               ctrl.pcwritecond = 1'b1;
               ctrl.pcsource    = PCSRC_ALUOUT;
               ctrl.instr_done  = 1'b1;
            end
            ST_JUMP: begin
               ctrl.pcwrite    = 1'b1;
               ctrl.pcsource   = PCSRC_JUMP;
               ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute for
// R-type, addi, j, beq, lw and sw, stretching memory states on mem_ready=0.
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsource,
   output logic       illegal,
   output logic       instr_done,
   output logic [3:0] state
);

   state_t     state_q;
   state_t     next_state;
   logic [5:0] op_q;
   ctrl_t      ctrl;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= ST_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= next_state;
         if (state_q == ST_DECODE) op_q <= opcode;
      end
   end

   // DECODE dispatches on the live opcode (the latch loads on this same edge);
   // later states see only op_q, so the IR may change freely afterwards.
   always_comb begin
      next_state = ST_FETCH;
      case (state_q)
         ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = ST_MEMADR;
               OP_RTYPE:     next_state = ST_EXEC;
               OP_ADDI:      next_state = ST_ADDIEX;
               OP_BEQ:       next_state = ST_BRANCH;
               OP_J:         next_state = ST_JUMP;
               default:      next_state = ST_FETCH;
            endcase
         end
         ST_MEMADR: next_state = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
         ST_MEMRD:  next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
         ST_MEMWR:  next_state = mem_ready ? ST_FETCH : ST_MEMWR;
         ST_EXEC:   next_state = ST_ALUWB;
         ST_ADDIEX: next_state = ST_ADDIWB;
         default:   next_state = ST_FETCH;
      endcase
   end

   mc_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .rst       (rst),
      .ctrl      (ctrl)
   );

   assign pcwrite     = ctrl.pcwrite;
   assign pcwritecond = ctrl.pcwritecond;
   assign iord        = ctrl.iord;
   assign memread     = ctrl.memread;
   assign memwrite    = ctrl.memwrite;
   assign irwrite     = ctrl.irwrite;
   assign memtoreg    = ctrl.memtoreg;
   assign regdst      = ctrl.regdst;
   assign regwrite    = ctrl.regwrite;
   assign alusrca     = ctrl.alusrca;
   assign alusrcb     = ctrl.alusrcb;
   assign aluop       = ctrl.aluop;
   assign pcsource    = ctrl.pcsource;
   assign instr_done  = ctrl.instr_done;
   assign illegal     = !rst && (state_q == ST_DECODE) && !is_legal_op(opcode);
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction queues its expected
// per-cycle state/control vector, then the queue is drained against the DUT.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdst, regwrite, alusrca, illegal, instr_done;
   logic [1:0] alusrcb, aluop, pcsource;
   logic [3:0] state;

   typedef struct {
      logic [3:0]  st;
      logic        mr;
      logic [5:0]  op;
      logic [21:0] exp;
   } entry_t;

   entry_t sb[$];
   int     errors = 0;
   int     checks = 0;
   int     done_count;

   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
      .pcsource(pcsource), .illegal(illegal), .instr_done(instr_done),
      .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b001000, 6'b000010, 6'b000100, 6'b100011, 6'b101011};
   endfunction

   // Expected {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
   // memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal, instr_done}.
   function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic mr, input logic [5:0] op);
      logic pw = 0, pwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
      logic ill = 0, dn = 0;
      logic [1:0] sb_ = 2'b00, ao = 2'b00, ps = 2'b00;
      case (st)
         4'd0:  begin mrd = 1; sb_ = 2'b01; irw = mr; pw = mr; end
         4'd1:  begin sb_ = 2'b11; ill = !legal(op); end
         4'd2, 4'd10: begin sa = 1; sb_ = 2'b10; end
         4'd3:  begin mrd = 1; io = 1; end
         4'd4:  begin rw = 1; m2r = 1; dn = 1; end
         4'd5:  begin mwr = 1; io = 1; dn = mr; end
         4'd6:  begin sa = 1; ao = 2'b10; end
         4'd7:  begin rw = 1; rd = 1; dn = 1; end
         4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
         4'd9:  begin pw = 1; ps = 2'b10; dn = 1; end
         4'd11: begin rw = 1; dn = 1; end
         default: ;
      endcase
      return {st, pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb_, ao, ps, ill, dn};
   endfunction

   task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op);
      entry_t e;
      e.st = st; e.mr = mr; e.op = op; e.exp = exp_vec(st, mr, op);
      sb.push_back(e);
   endtask

   // Drives each queued cycle's inputs, compares mid-cycle, then advances.
   task automatic drain(input string name);
      entry_t e;
      logic [21:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         mem_ready = e.mr;
         opcode    = e.op;
         @(negedge clk);
         obs = {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal, instr_done};
         checks++;
         if (obs !== e.exp) begin
            errors++;
            $display("FAIL %s exp_state=%0d: got %h required %h", name, e.st, obs, e.exp);
         end
         if (instr_done === 1'b1) done_count++;
         @(posedge clk);
         #1;
      end
   endtask

   // Queues one instruction from FETCH; after DECODE the IR input is scrambled
   // so only the latched opcode can steer MEMADR.
   task automatic queue_instr(input logic [5:0] op, input int fw, input int mw);
      logic [5:0] scr = ~op;
      for (int i = 0; i < fw; i++) push(4'd0, 1'b0, op);
      push(4'd0, 1'b1, op);
      push(4'd1, 1'b0, op);
      case (op)
         6'b100011: begin
            push(4'd2, 1'b0, scr);
            for (int i = 0; i < mw; i++) push(4'd3, 1'b0, scr);
            push(4'd3, 1'b1, scr);
            push(4'd4, 1'b0, scr);
         end
         6'b101011: begin
            push(4'd2, 1'b0, scr);
            for (int i = 0; i < mw; i++) push(4'd5, 1'b0, scr);
            push(4'd5, 1'b1, scr);
         end
         6'b000000: begin push(4'd6, 1'b0, scr); push(4'd7, 1'b0, scr); end
         6'b001000: begin push(4'd10, 1'b0, scr); push(4'd11, 1'b0, scr); end
         6'b000100: push(4'd8, 1'b0, scr);
         6'b000010: push(4'd9, 1'b0, scr);
         default: ;
      endcase
   endtask

   task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
      int want;
      done_count = 0;
      queue_instr(op, fw, mw);
      want = legal(op) ? 1 : 0;
      drain(name);
      checks++;
      if (done_count != want) begin
         errors++;
         $display("FAIL %s_done_pulses: got %0d required %0d", name, done_count, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; opcode = 6'b000010; mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({state, pcwrite, irwrite, regwrite, memwrite, pcwritecond, illegal, instr_done} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got state=%0d pw=%b irw=%b rw=%b mw=%b pwc=%b ill=%b dn=%b required all 0",
                  state, pcwrite, irwrite, regwrite, memwrite, pcwritecond, illegal, instr_done);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (state !== 4'd1) begin
         errors++;
         $display("FAIL reset_first_edge: got state=%0d required 1", state);
      end
      done_count = 0;
      push(4'd1, 1'b0, 6'b000010);
      push(4'd9, 1'b0, 6'b111101);
      drain("reset_then_j");
   endtask

   task automatic test_async_reset_memrd();
      push(4'd0, 1'b1, 6'b100011);
      push(4'd1, 1'b0, 6'b100011);
      push(4'd2, 1'b0, 6'b011100);
      push(4'd3, 1'b0, 6'b011100);
      drain("lw_to_memrd");
      checks++;
      if (state !== 4'd3) begin
         errors++;
         $display("FAIL memrd_before_rst: got state=%0d required 3", state);
      end
      mem_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({state, regwrite, memtoreg, instr_done} !== 7'd0) begin
         errors++;
         $display("FAIL async_rst_memrd: got state=%0d rw=%b m2r=%b dn=%b required 0 0 0 0",
                  state, regwrite, memtoreg, instr_done);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_instr("addi_after_rst", 6'b001000, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b001000, 6'b000000, 6'b000100, 6'b000010};
      for (int n = 0; n < 12; n++) begin
         run_instr("b2b", ops[n % 6], int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      run_instr("lw", 6'b100011, 0, 0);
      run_instr("sw_wait2", 6'b101011, 0, 2);
      run_instr("beq", 6'b000100, 0, 0);
      run_instr("illegal", 6'b111111, 0, 0);
      run_instr("rtype_fetch_wait3", 6'b000000, 3, 0);
      run_instr("lw_memrd_wait", 6'b100011, 1, 2);
      run_instr("j", 6'b000010, 0, 0);
      test_async_reset_memrd();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
